// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern detector: FSM encoding and a
// ceiling-log2 helper used to size the fill counter.
package seq_pkg;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and soft clear; sticks at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_pattern_det.sv
// Serial PLEN-bit pattern detector on the sampled bit stream, with overlap or
// non-overlap restart, registered match pulse and saturating match count.
module seq_pattern_det
    import seq_pkg::*;
#(
    parameter int             PLEN    = 4,
    parameter logic [PLEN-1:0] PATTERN = 4'b1011,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic          din,
    output logic          match,
    output logic          armed,
    output logic [CW-1:0] match_cnt
);

    localparam int            FW        = (clog2(PLEN) < 1) ? 1 : clog2(PLEN);
    localparam logic [FW-1:0] FILL_LAST = FW'(PLEN - 1);

    logic [PLEN-2:0] hist_q, hist_d;
    logic [FW-1:0]   fill_q, fill_d;
    state_e          state_q, state_d;
    logic            match_q, match_d;
    logic            armed_q, armed_d;
    logic [PLEN-1:0] cand;

    always_comb begin
        cand    = {hist_q, din};
        hist_d  = hist_q;
        fill_d  = fill_q;
        state_d = state_q;
        match_d = 1'b0;
        if (en) begin
            hist_d = cand[PLEN-2:0];
            unique case (state_q)
                ST_FILL: begin
                    fill_d = fill_q + 1'b1;
                    if (fill_d == FILL_LAST) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (cand == PATTERN) begin
                        match_d = 1'b1;
                        // Non-overlap: discard the matched bits so PLEN fresh ones are needed
                        if (!OVERLAP) begin
                            state_d = ST_FILL;
                            fill_d  = '0;
                            hist_d  = '0;
                        end
                    end
                end
            endcase
        end
        armed_d = (state_d == ST_ARMED);
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hist_q  <= '0;
            fill_q  <= '0;
            state_q <= ST_FILL;
            match_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            state_q <= state_d;
            match_q <= match_d;
            armed_q <= armed_d;
        end
    end

    // Counter clears on rst/clr itself, so a completing bit on a clearing edge never counts
    sat_counter #(.W(CW)) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (match_d),
        .cnt (match_cnt)
    );

    assign match = match_q;
    assign armed = armed_q;

endmodule
